muacm_in_arb: RTL and testbench

// - Round-robin arbiter that shares the single muacm IN pipe (in_data/last/valid/ready)

---
 rtl/muacm_in_arb.sv | 162 ++++++++++++++++
 tb/tb_muacm_in_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muacm_in_arb.sv
// muacm_in_arb: packet-granular round-robin arbiter sharing the muacm IN pipe
// between N_SRC byte-stream producers, plus in_flush_now generation.
// Optional feature macro: MUACM_ARB_TIMEOUT_EN (stall-timeout grant revocation).

// Per-source slice: gates the source onto the shared pipe when selected.
module muacm_in_arb_lane (
  input  logic       sel,
  input  logic [7:0] data,
  input  logic       last,
  input  logic       valid,
  input  logic       in_ready,
  output logic       ready,
  output logic [7:0] data_m,
  output logic       last_m,
  output logic       valid_m
);
  assign ready   = sel & in_ready;
  assign data_m  = sel ? data : 8'h00;
  assign last_m  = sel & last;
  assign valid_m = sel & valid;
endmodule

module muacm_in_arb #(
  parameter int N_SRC     = 2,
  parameter int MAX_BURST = 64,
  parameter int IDLE_TO   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ready,
  output logic [7:0]         in_data,
  output logic               in_last,
  output logic               in_valid,
  input  logic               in_ready,
  output logic               in_flush_now,
  output logic [2:0]         grant_id
);
  typedef enum logic {IDLE, GNT} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  rr_ptr;
  logic [7:0]                  byte_cnt;
  logic                        flush_q;
  logic [N_SRC-1:0]            sel;
  logic [N_SRC-1:0][7:0]       data_m;
  logic [N_SRC-1:0]            last_m, valid_m;
  logic [2:0]                  pick;
  logic                        any_valid;
  logic                        xfer, rel_last, rel_cap, rel_to, release_now;
  logic [2:0]                  next_ptr;

  // One slice per source; only the owner in GNT reaches the pipe.
  for (genvar i = 0; i < N_SRC; i++) begin : g_lane
    assign sel[i] = (state_q == GNT) && (grant_id == 3'(i));
    muacm_in_arb_lane u_lane (
      .sel      (sel[i]),
      .data     (src_data[8*i +: 8]),
      .last     (src_last[i]),
      .valid    (src_valid[i]),
      .in_ready (in_ready),
      .ready    (src_ready[i]),
      .data_m   (data_m[i]),
      .last_m   (last_m[i]),
      .valid_m  (valid_m[i])
    );
  end

  // OR-merge the one-hot gated slices onto the pipe.
  always_comb begin
    in_data = '0;
    for (int i = 0; i < N_SRC; i++) in_data = in_data | data_m[i];
    in_last  = |last_m;
    in_valid = |valid_m;
  end

  // Round-robin pick: nearest valid source at or above rr_ptr, wrapping.
  always_comb begin
    int best_d;
    int d;
    pick   = '0;
    best_d = N_SRC;
    d      = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i]) begin
        d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + N_SRC - int'(rr_ptr);
        if (d < best_d) begin
          best_d = d;
          pick   = 3'(i);
        end
      end
    end
  end

  assign any_valid   = |src_valid;
  assign xfer        = in_valid & in_ready;
  assign rel_last    = xfer & in_last;
  assign rel_cap     = xfer & (byte_cnt == 8'(MAX_BURST - 1));
  assign release_now = rel_last | rel_cap | rel_to;
  assign next_ptr    = (grant_id == 3'(N_SRC - 1)) ? 3'd0 : grant_id + 3'd1;

`ifdef MUACM_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(IDLE_TO + 1);
  logic [STALL_W-1:0] stall_cnt;

  assign rel_to = (state_q == GNT) & ~in_valid & (stall_cnt == STALL_W'(IDLE_TO - 1));

  // Consecutive owner-stall cycles; any valid cycle or leaving GNT clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt <= '0;
    else if (state_q != GNT || in_valid)   stall_cnt <= '0;
    else if (!rel_to)                      stall_cnt <= stall_cnt + 1'b1;
    else                                   stall_cnt <= '0;
  end
`else
  logic unused_idle_to;
  assign unused_idle_to = ^IDLE_TO;
  assign rel_to         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: arbitrate in IDLE, hold grant until a release event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid)   state_d = GNT;
      GNT:     if (release_now) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Grant owner, rr pointer, burst counter and flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= rel_last;
      if (state_q == IDLE) begin
        byte_cnt <= '0;
        if (any_valid) grant_id <= pick;
      end else if (release_now) begin
        rr_ptr   <= next_ptr;
        byte_cnt <= '0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

  assign in_flush_now = flush_q;

endmodule

// File: tb/tb_muacm_in_arb.sv
// Directed bench for muacm_in_arb: N_SRC=2, MAX_BURST=64, IDLE_TO=4.
module tb_muacm_in_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src_data;
  logic [1:0]  src_last, src_valid, src_ready;
  logic [7:0]  in_data;
  logic        in_last, in_valid, in_ready, in_flush_now;
  logic [2:0]  grant_id;

  muacm_in_arb #(.N_SRC(2), .MAX_BURST(64), .IDLE_TO(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_last(src_last),
    .src_valid(src_valid), .src_ready(src_ready), .in_data(in_data),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .in_flush_now(in_flush_now), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  logic [7:0] q0[$], q1[$];
  logic       ql0[$], ql1[$];
  logic [7:0] obs_d[$];
  int         obs_c[$], fl_c[$];
  int         cyc_n = 0;
  int         n_vec = 0, n_bad = 0;
  int         mir_n = 0, mir_bad = 0;
  bit         mir_on = 0, tog = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int od(input int i);
    return (i < obs_d.size()) ? int'(obs_d[i]) : -1;
  endfunction
  function automatic int oc(input int i);
    return (i < obs_c.size()) ? obs_c[i] : -1000;
  endfunction
  function automatic int fc(input int i);
    return (i < fl_c.size()) ? fl_c[i] : -1000;
  endfunction

  task automatic drive();
    src_valid[0]  = q0.size() > 0;
    src_data[7:0] = (q0.size() > 0) ? q0[0] : 8'h00;
    src_last[0]   = (ql0.size() > 0) ? ql0[0] : 1'b0;
    src_valid[1]  = q1.size() > 0;
    src_data[15:8]= (q1.size() > 0) ? q1[0] : 8'h00;
    src_last[1]   = (ql1.size() > 0) ? ql1[0] : 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      bit p0, p1;
      int own;
      @(negedge clk);
      if (mir_on && in_valid) begin
        own = (obs_d.size() < 5) ? 0 : 1;
        mir_n++;
        if (src_ready !== (in_ready ? 2'(1 << own) : 2'b00)) mir_bad++;
      end
      if (in_valid && in_ready) begin
        obs_d.push_back(in_data);
        obs_c.push_back(cyc_n);
      end
      if (in_flush_now) fl_c.push_back(cyc_n);
      p0 = src_ready[0];
      p1 = src_ready[1];
      @(posedge clk);
      #1;
      cyc_n++;
      if (p0 && q0.size() > 0) begin void'(q0.pop_front()); void'(ql0.pop_front()); end
      if (p1 && q1.size() > 0) begin void'(q1.pop_front()); void'(ql1.pop_front()); end
      if (tog) in_ready = ~in_ready;
      drive();
    end
  endtask

  task automatic rst_pulse(input bit do_chk);
    #2 rst_n = 1'b0;
    #1;
    if (do_chk) begin
      chk("rst_in_valid", in_valid, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_flush", in_flush_now, 0);
      chk("rst_grant_id", grant_id, 0);
    end
    q0.delete(); q1.delete(); ql0.delete(); ql1.delete();
    obs_d.delete(); obs_c.delete(); fl_c.delete();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    if (s == 0) begin q0.push_back(d); ql0.push_back(l); end
    else        begin q1.push_back(d); ql1.push_back(l); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("init_in_valid", in_valid, 0);
    chk("init_src_ready", src_ready, 0);
    chk("init_flush", in_flush_now, 0);
    chk("init_grant_id", grant_id, 0);
    rst_n = 1'b1;

    // Reset mid-GNT; rr_ptr has moved to 1 but must return to 0.
    push(0, 8'h01, 1);
    push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 1);
    drive();
    step(4);
    chk("pre_rst_in_valid", in_valid, 1);
    chk("pre_rst_grant_id", grant_id, 1);
    rst_pulse(1);
    push(0, 8'h21, 1); push(1, 8'h31, 1);
    drive();
    step(6);
    chk("post_rst_first", od(0), 'h21);
    chk("post_rst_second", od(1), 'h31);

    // Two 3-byte packets, round-robin with one bubble and two flushes.
    rst_pulse(0);
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    push(1, 8'hB1, 0); push(1, 8'hB2, 0); push(1, 8'hB3, 1);
    drive();
    step(12);
    chk("rr_count", obs_d.size(), 6);
    chk("rr_d0", od(0), 'hA1); chk("rr_d1", od(1), 'hA2); chk("rr_d2", od(2), 'hA3);
    chk("rr_d3", od(3), 'hB1); chk("rr_d4", od(4), 'hB2); chk("rr_d5", od(5), 'hB3);
    chk("rr_bubble", oc(3) - oc(2), 2);
    chk("rr_flush_n", fl_c.size(), 2);
    chk("rr_flush_a", fc(0) - oc(2), 1);
    chk("rr_flush_b", fc(1) - oc(5), 1);

    // Burst cap, source 0 alone: resumes at byte 65 after one bubble.
    rst_pulse(0);
    for (int i = 0; i < 100; i++) push(0, 8'(i), 0);
    drive();
    step(110);
    chk("cap_count", obs_d.size(), 100);
    chk("cap_b63", od(63), 63);
    chk("cap_b64", od(64), 64);
    chk("cap_first64", oc(63) - oc(0), 63);
    chk("cap_bubble", oc(64) - oc(63), 2);
    chk("cap_no_flush", fl_c.size(), 0);

    // Burst cap with source 1 waiting: it gets the pipe after byte 64.
    rst_pulse(0);
    for (int i = 0; i < 100; i++) push(0, 8'(i), 0);
    push(1, 8'hB0, 1);
    drive();
    step(110);
    chk("cap2_count", obs_d.size(), 101);
    chk("cap2_b63", od(63), 63);
    chk("cap2_src1", od(64), 'hB0);
    chk("cap2_resume", od(65), 64);
    chk("cap2_flush_n", fl_c.size(), 1);
    chk("cap2_flush_at", fc(0) - oc(64), 1);

    // in_ready toggling: no loss/dup, src_ready only on the owner.
    rst_pulse(0);
    for (int i = 0; i < 5; i++) push(0, 8'(8'h10 + i), i == 4);
    push(1, 8'h20, 0); push(1, 8'h21, 1);
    mir_on = 1; tog = 1;
    drive();
    step(40);
    mir_on = 0; tog = 0; in_ready = 1'b1;
    chk("tog_count", obs_d.size(), 7);
    for (int i = 0; i < 5; i++) chk($sformatf("tog_a%0d", i), od(i), 'h10 + i);
    chk("tog_b0", od(5), 'h20);
    chk("tog_b1", od(6), 'h21);
    chk("tog_mirror_seen", mir_n > 10, 1);
    chk("tog_mirror_bad", mir_bad, 0);

    // Source 1 stalls after 2 bytes while source 0 waits.
    rst_pulse(0);
    push(1, 8'hC0, 0); push(1, 8'hC1, 0);
    drive();
    step(2);
    push(0, 8'hD0, 1);
    drive();
    step(30);
`ifdef MUACM_ARB_TIMEOUT_EN
    chk("to_count", obs_d.size(), 3);
    chk("to_d2", od(2), 'hD0);
    chk("to_gap", oc(2) - oc(1), 6);
    chk("to_flush_n", fl_c.size(), 1);
    chk("to_flush_at", fc(0) - oc(2), 1);
`else
    chk("hold_count", obs_d.size(), 2);
    chk("hold_grant", grant_id, 1);
    chk("hold_src_ready0", src_ready[0], 0);
    chk("hold_flush_n", fl_c.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
